// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bundle types and mstatus fields.
// Imported by the CSR register file and its storage block.
package csr_pkg;

  localparam int CSR_OPS_N = 3;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Direct-mode vectors and word-aligned return PCs.
  localparam logic [63:0] CSR_ALIGN_MASK = ~64'h3;

  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
    logic        we;
  } csr_op_t;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_CSR   = 2'd1,
    KIND_ECALL = 2'd2,
    KIND_MRET  = 2'd3
  } csr_kind_t;

  function automatic logic csr_known(
    input logic [11:0] addr
  );
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MSTATUS,
      CSR_MIE,
      CSR_MTVEC,
      CSR_MSCRATCH,
      CSR_MEPC,
      CSR_MCAUSE,
      CSR_MTVAL,
      CSR_MIP,
      CSR_MCYCLE,
      CSR_MINSTRET: hit = 1'b1;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_regs.sv
// csr_regs: machine-mode CSR storage with one write port,
// free-running counters and a combinational read mux.
module csr_regs
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        retire,
  input  logic [11:0] rd_addr,
  output logic [63:0] rd_data,
  output logic        wr_miss,
  output logic [63:0] mtvec,
  output logic [63:0] mepc
);

  logic [63:0] mstatus;
  logic [63:0] mie;
  logic [63:0] mscratch;
  logic [63:0] mcause;
  logic [63:0] mtval;
  logic [63:0] mip;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Flag writes that land on an address with no backing register.
  always_comb begin
    wr_miss = wr_en && !csr_known(wr_addr);
  end

  // Counters tick first; an explicit write later in the block wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus  <= '0;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mip      <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (retire) begin
        minstret <= minstret + 64'd1;
      end
      if (wr_en) begin
        case (wr_addr)
          CSR_MSTATUS:  mstatus  <= wr_data;
          CSR_MIE:      mie      <= wr_data;
          CSR_MTVEC:    mtvec    <= wr_data & CSR_ALIGN_MASK;
          CSR_MSCRATCH: mscratch <= wr_data;
          CSR_MEPC:     mepc     <= wr_data & CSR_ALIGN_MASK;
          CSR_MCAUSE:   mcause   <= wr_data;
          CSR_MTVAL:    mtval    <= wr_data;
          CSR_MIP:      mip      <= wr_data;
          CSR_MCYCLE:   mcycle   <= wr_data;
          CSR_MINSTRET: minstret <= wr_data;
          default: ;
        endcase
      end
    end
  end

  // Read committed state only; unknown addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_MSTATUS:  rd_data = mstatus;
      CSR_MIE:      rd_data = mie;
      CSR_MTVEC:    rd_data = mtvec;
      CSR_MSCRATCH: rd_data = mscratch;
      CSR_MEPC:     rd_data = mepc;
      CSR_MCAUSE:   rd_data = mcause;
      CSR_MTVAL:    rd_data = mtval;
      CSR_MIP:      rd_data = mip;
      CSR_MCYCLE:   rd_data = mcycle;
      CSR_MINSTRET: rd_data = minstret;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: accepts retiring CSR bundles, serializes them onto
// one write port, and raises trap/return redirects.
module csr_file
  import csr_pkg::*;
#(
  parameter int N_OPS = CSR_OPS_N
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  csr_op_t     commit_ops [N_OPS],
  input  csr_kind_t   commit_kind,
  input  logic        retire,
  input  logic [11:0] rd_addr,
  output logic [63:0] rd_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        wr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  csr_op_t     pend [N_OPS];
  csr_op_t     src  [N_OPS];
  csr_op_t     rest [N_OPS];
  csr_kind_t   kind_q;
  csr_kind_t   kind_src;
  logic        src_live;
  logic        found;
  logic        more;
  logic        accept;
  logic        fin;
  logic        redir_kind;
  logic        mret_q;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_miss;
  logic [63:0] mtvec;
  logic [63:0] mepc;

  // Feed the write port from the live bundle in IDLE, else the buffer.
  always_comb begin
    src      = pend;
    src_live = 1'b1;
    kind_src = kind_q;
    if (state == IDLE) begin
      src      = commit_ops;
      src_live = commit_valid;
      kind_src = commit_kind;
    end
  end

  // Take the lowest active slot; whatever is still active remains.
  always_comb begin
    found   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rest    = src;
    for (int i = 0; i < N_OPS; i++) begin
      if (!found && src[i].we) begin
        found       = 1'b1;
        wr_addr     = src[i].addr;
        wr_data     = src[i].data;
        rest[i].we  = 1'b0;
      end
    end
    more = 1'b0;
    for (int i = 0; i < N_OPS; i++) begin
      more = more | rest[i].we;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stay in DRAIN until the edge that writes the final pending slot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept && more) state_nxt = DRAIN;
      DRAIN: if (!more)          state_nxt = IDLE;
    endcase
  end

  // Handshake, write strobe and bundle-finished decode.
  always_comb begin
    commit_ready = (state == IDLE);
    accept       = commit_ready && commit_valid;
    wr_en        = src_live && found;
    fin          = src_live && !more;
    redir_kind   = (kind_src == KIND_ECALL)
                || (kind_src == KIND_MRET);
  end

  // Hold leftover slots and the bundle kind across DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OPS; i++) begin
        pend[i] <= '0;
      end
      kind_q <= KIND_NONE;
    end else if (src_live) begin
      pend <= rest;
      if (state == IDLE) begin
        kind_q <= commit_kind;
      end
    end
  end

  // Redirect and error pulses follow the edge that finished the work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      mret_q         <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      redirect_valid <= fin && redir_kind;
      mret_q         <= (kind_src == KIND_MRET);
      wr_err         <= wr_miss;
    end
  end

  // Registers already hold every write of the bundle by the pulse cycle.
  always_comb begin
    redirect_pc = '0;
    if (redirect_valid) begin
      redirect_pc = mret_q ? mepc : mtvec;
    end
  end

  csr_regs u_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .retire  (retire),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_miss (wr_miss),
    .mtvec   (mtvec),
    .mepc    (mepc)
  );

endmodule
